// File: rtl/uart_tx_sched.sv
// Byte FIFO feeding a UART transmitter through an IDLE/SEND/BUSY/GAP handshake.
// Define UART_TX_SCHED_IRQ_EN to build the end-of-queue irq pulse; otherwise irq is tied low.
module uart_tx_sched #(
  parameter int DEPTH = 8,
  parameter int TMO   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic                     tx_status,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     tmo_err,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [TW-1:0] tmr_t;
  typedef enum logic [1:0] {IDLE, SEND, BUSY, GAP} state_t;

  logic [7:0] mem [DEPTH];
  ptr_t       rd_ptr, wr_ptr;
  tmr_t       tmr;
  state_t     state, state_nxt;

  logic pop, push_ok, ovf_set, tmo_hit, en_drop;

  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  // flush wins over a simultaneous write; the byte is silently dropped
  assign push_ok = wr_en && !full && !flush;
  assign ovf_set = wr_en && full && !flush;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    en_drop   = 1'b0;
    case (state)
      IDLE: if (!empty && !flush) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx_status) begin
          state_nxt = BUSY;
        end else if (tmr == tmr_t'(TMO - 1)) begin
          tmo_hit   = 1'b1;
          en_drop   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY: if (tx_status) begin
        en_drop   = 1'b1;
        state_nxt = GAP;
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
      tmr     <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        tx_en   <= 1'b1;
        tmr     <= '0;
      end else begin
        if (en_drop) tx_en <= 1'b0;
        if (state == SEND) tmr <= tmr + tmr_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)     rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as clr_err keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      ovf     <= (ovf && !clr_err) || ovf_set;
      tmo_err <= (tmo_err && !clr_err) || tmo_hit;
    end
  end

`ifdef UART_TX_SCHED_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (state == GAP) && empty;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based reference model compared every cycle,
// a simple UART responder, and directed scenarios with literal expectations.
module tb_uart_tx_sched;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;
`ifdef UART_TX_SCHED_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, flush = 1'b0, clr_err = 1'b0, tx_status = 1'b1;
  logic [7:0] wr_data = '0;
  logic [7:0] tx_data;
  logic tx_en, full, empty, ovf, tmo_err, irq;
  logic [$clog2(DEPTH):0] count;

  int checks = 0, errors = 0;

  uart_tx_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_err(clr_err), .tx_status(tx_status), .tx_data(tx_data), .tx_en(tx_en),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .tmo_err(tmo_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue of pending bytes plus the handshake phase with the UART
  byte unsigned m_q[$];
  int   m_ph = 0;   // 0 waiting for data, 1 offered to UART, 2 UART sending, 3 spacing
  int   m_wait = 0;
  logic [7:0] m_data = '0;
  logic m_en = 1'b0, m_ovf = 1'b0, m_tmo = 1'b0, m_irq = 1'b0;
  bit   started = 0;

  always @(posedge clk) begin : model
    bit go, full_now, was_empty, ovf_set, tmo_set;
    started = 1;
    if (reset) begin
      m_q.delete();
      m_ph = 0; m_data = '0; m_en = 0; m_ovf = 0; m_tmo = 0; m_irq = 0;
    end else begin
      full_now  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      go        = (m_ph == 0) && !was_empty && !flush;
      ovf_set = 0; tmo_set = 0; m_irq = 0;
      case (m_ph)
        0: if (go) begin m_data = m_q[0]; m_en = 1; m_ph = 1; m_wait = 0; end
        1: if (!tx_status) m_ph = 2;
           else begin
             m_wait++;
             if (m_wait == TMO) begin m_en = 0; tmo_set = 1; m_ph = 0; end
           end
        2: if (tx_status) begin m_en = 0; m_ph = 3; end
        default: begin m_ph = 0; m_irq = (IRQ_EXP == 1) && was_empty; end
      endcase
      if (flush) m_q.delete();
      else begin
        if (go) void'(m_q.pop_front());
        if (wr_en) begin
          if (full_now) ovf_set = 1;
          else m_q.push_back(wr_data);
        end
      end
      m_ovf = (m_ovf && !clr_err) || ovf_set;
      m_tmo = (m_tmo && !clr_err) || tmo_set;
    end
  end

  always @(negedge clk) if (started) begin
    chk("tx_data", tx_data, m_data);
    chk("tx_en", tx_en, m_en);
    chk("count", count, m_q.size());
    chk("full", full, m_q.size() == DEPTH);
    chk("empty", empty, m_q.size() == 0);
    chk("ovf", ovf, m_ovf);
    chk("tmo_err", tmo_err, m_tmo);
    chk("irq", irq, m_irq);
  end

  // UART responder: on each tx_en rise log the byte and, unless stuck, go busy for ulen cycles
  byte unsigned sent[$];
  int   ucnt = 0, ulen = 10, low_run = 0, min_gap = 1000, irq_cnt = 0;
  bit   ustuck = 0, seen_rise = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (irq === 1'b1) irq_cnt++;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) tx_status = 1'b1;
    end
    if (tx_en === 1'b1 && prev_en !== 1'b1) begin
      sent.push_back(tx_data);
      if (seen_rise && low_run < min_gap) min_gap = low_run;
      seen_rise = 1;
      if (!ustuck) begin tx_status = 1'b0; ucnt = ulen; end
    end
    low_run = (tx_en === 1'b1) ? 0 : low_run + 1;
    prev_en = tx_en;
  end

  function automatic int sent_at(input int idx);
    if (idx < sent.size()) return int'(sent[idx]);
    return -1;
  endfunction

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while (!(m_ph == 0 && m_q.size() == 0 && ucnt == 0 && tx_en === 1'b0) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk({name, " drain in time"}, n < 2000, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, s0, i0, n;
    logic [7:0] b;
    byte unsigned exp_q[$];

    // Reset state
    @(negedge clk);
    chk("rst empty", empty, 1); chk("rst full", full, 0); chk("rst tx_en", tx_en, 0);
    chk("rst irq", irq, 0);     chk("rst count", count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: tx_en one edge after write, falls one edge after UART finishes
    i0 = irq_cnt; s0 = sent.size();
    push(8'h55);
    @(negedge clk);
    chk("s1 tx_data", tx_data, 8'h55); chk("s1 tx_en", tx_en, 1);
    hi = 0;
    while (tx_en === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    chk("s1 tx_en high cycles", hi, 11);
    wait_quiet("s1");
    chk("s1 irq pulses", irq_cnt - i0, IRQ_EXP);
    chk("s1 sent", sent_at(s0), 8'h55);

    // Fill to full behind a long byte in flight, then overflow
    ulen = 30; s0 = sent.size();
    push(8'hA0);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push(i[7:0]);
    chk("s2 count", count, 8); chk("s2 full", full, 1);
    push(8'hFF);
    chk("s2 ovf", ovf, 1); chk("s2 count after ovf", count, 8);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("s2 ovf cleared", ovf, 0);
    wait_quiet("s2");
    chk("s2 sent count", sent.size() - s0, 9);
    chk("s2 sent head", sent_at(s0), 8'hA0);
    for (int k = 1; k <= 8; k++) chk("s2 order", sent_at(s0 + k), k);
    ulen = 10;

    // Timeout: UART never goes busy
    ustuck = 1; s0 = sent.size();
    push(8'h11); push(8'h22);
    chk("s3 tx_en", tx_en, 1); chk("s3 tx_data", tx_data, 8'h11);
    hi = 0;
    while (tx_en === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    ustuck = 0;
    chk("s3 tx_en high cycles", hi, TMO);
    chk("s3 tmo_err", tmo_err, 1); chk("s3 tx_en low", tx_en, 0);
    wait_quiet("s3");
    chk("s3 first", sent_at(s0), 8'h11); chk("s3 next", sent_at(s0 + 1), 8'h22);
    chk("s3 sent count", sent.size() - s0, 2);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("s3 tmo cleared", tmo_err, 0);

    // Flush while the first byte is with the UART
    s0 = sent.size();
    push(8'h31); push(8'h32); push(8'h33);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    chk("s4 count", count, 0); chk("s4 empty", empty, 1); chk("s4 in flight", tx_en, 1);
    wait_quiet("s4");
    chk("s4 sent count", sent.size() - s0, 1); chk("s4 sent", sent_at(s0), 8'h31);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    @(negedge clk);
    flush = 1'b0; wr_en = 1'b0;
    chk("s4b count", count, 0); chk("s4b ovf", ovf, 0);
    @(negedge clk);
    chk("s4b tx_en", tx_en, 0); chk("s4b nothing sent", sent.size() - s0, 1);

    // Reset while the UART is busy
    push(8'h44); push(8'h45);
    @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("s5 tx_en", tx_en, 0); chk("s5 count", count, 0); chk("s5 empty", empty, 1);
    chk("s5 tx_data", tx_data, 0);
    n = 0;
    while (ucnt != 0 && n < 100) begin @(negedge clk); n++; end
    chk("s5 uart settles", n < 100, 1);
    push(8'h46);
    @(negedge clk);
    chk("s5 idle resumes", tx_en, 1); chk("s5 tx_data", tx_data, 8'h46);
    wait_quiet("s5");

    // Pointer wrap: 3*DEPTH bytes with flow control
    ulen = 2; s0 = sent.size(); exp_q.delete();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      n = 0;
      while (m_q.size() == DEPTH && n < 500) begin @(negedge clk); n++; end
      b = 8'(i * 37 + 5);
      exp_q.push_back(b);
      push(b);
    end
    wait_quiet("s6");
    chk("s6 sent count", sent.size() - s0, 3 * DEPTH);
    for (int k = 0; k < 3 * DEPTH; k++) chk("s6 order", sent_at(s0 + k), exp_q[k]);
    chk("s6 ovf", ovf, 0);

    chk("min tx_en low gap", min_gap >= 1, 1);
`ifndef UART_TX_SCHED_IRQ_EN
    chk("irq never pulses", irq_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes; legal values are powers of two from 2 to 64.
REQ-002 The block SHALL have parameter TMO, default 16, meaning the maximum number of cycles to wait for the UART to go busy after tx_en rises.
REQ-003 The block SHALL have port clk  input  1  system clock; all logic uses the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port wr_en  input  1  push wr_data into the FIFO.
REQ-006 The block SHALL have port wr_data  input  8  byte to queue.
REQ-007 The block SHALL have port flush  input  1  discard all queued bytes.
REQ-008 The block SHALL have port clr_err  input  1  clear the sticky flags.
REQ-009 The block SHALL have port tx_status  input  1  UART transmitter state; 1 = idle/finished, 0 = sending.
REQ-010 The block SHALL have port tx_data  output  8  byte presented to the UART.
REQ-011 The block SHALL have port tx_en  output  1  UART send enable.
REQ-012 The block SHALL have port full, empty  output  1 each  FIFO status.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  number of queued bytes.
REQ-014 The block SHALL have port ovf, tmo_err  output  1 each  sticky overflow and timeout flags.
REQ-015 The block SHALL have port irq  output  1  one-cycle done pulse.

Function
REQ-016 The FIFO SHALL be circular, with wrapping read and write pointers, full = (count==DEPTH), and empty = (count==0).
REQ-017 A wr_en while not full SHALL store the byte at the rising edge; count then increments unless a pop happens in the same cycle.
REQ-018 A wr_en while full SHALL be dropped and SHALL set ovf, even if a pop happens in the same cycle.
REQ-019 flush SHALL empty the FIFO at the edge, overriding any simultaneous wr_en (the byte is dropped, ovf unchanged); flush SHALL NOT affect the byte already in flight.
REQ-020 The FSM SHALL have states IDLE, SEND, BUSY and GAP.
REQ-021 IDLE with FIFO not empty SHALL, at the next edge, load the head into tx_data, set tx_en=1, pop, and go to SEND.
REQ-022 For a write into an empty FIFO in IDLE, tx_en SHALL rise at the first edge after the write edge.
REQ-023 SEND SHALL go to BUSY when tx_status==0.
REQ-024 SEND SHALL, after TMO cycles with tx_status==1, clear tx_en, set tmo_err, discard the byte, and go to IDLE.
REQ-025 BUSY SHALL, when tx_status==1, clear tx_en and go to GAP.
REQ-026 GAP SHALL last exactly one cycle and then go to IDLE, giving a minimum of one cycle with tx_en low between bytes.
REQ-027 tx_data SHALL hold stable from the load until the next load.
REQ-028 The timeout counter SHALL be cleared on entry to SEND.
REQ-029 When clr_err and a new error event occur in the same cycle, the set SHALL win.

Reset
REQ-030 While reset is high at an edge, the block SHALL clear both pointers, set count=0, clear tx_data, tx_en, ovf, tmo_err and irq, and set FSM=IDLE; reset mid-transfer abandons the byte.
REQ-031 Immediately after reset, the outputs SHALL be empty=1, full=0, tx_en=0, and irq=0.

Configuration
REQ-032 With macro UART_TX_SCHED_IRQ_EN defined, irq SHALL pulse high for exactly one cycle on the GAP->IDLE transition when the FIFO is empty, i.e. when the last byte completes.
REQ-033 Without UART_TX_SCHED_IRQ_EN, irq SHALL be tied to 0 and no irq logic SHALL be built; all other behaviour is identical.

Verification
REQ-034 Bench SHALL check: write 0x55 in IDLE at edge E0 -> tx_data=0x55 and tx_en=1 after E1; model UART drops tx_status for 10 cycles -> tx_en=0 one edge after tx_status returns to 1; irq pulses once (macro on).
REQ-035 Bench SHALL check: write 0x01..0x08 back-to-back with DEPTH=8 -> full=1 and count=8 after the 8th write; a 9th write 0xFF -> ovf=1 and 0xFF is never transmitted; 0x01..0x08 are sent in order with at least one tx_en-low cycle between bytes.
REQ-036 Bench SHALL check: tx_status held at 1 after tx_en rises -> tmo_err=1 and tx_en=0 after 16 cycles; the next queued byte is then sent normally.
REQ-037 Bench SHALL check: queue 3 bytes, flush while the first is in BUSY -> the first completes, count=0, empty=1, nothing further is sent; flush and wr_en in the same cycle -> count=0, ovf=0.
REQ-038 Bench SHALL check: reset asserted during BUSY -> tx_en=0, count=0 and FSM=IDLE after the edge; with the macro off, irq stays 0 throughout all scenarios.
REQ-039 Bench SHALL check: exercise pointer wrap by pushing and draining 3×DEPTH bytes -> output byte order matches input byte order.
